io_port_responder: RTL
======================

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 SHALL have parameter SW_PORT, default 8'h20: read-only switch input port ID.
REQ-003 SHALL have parameter LED_PORT, default 8'h40: LED output port ID.
REQ-004 SHALL have parameter SEG_PORT, default 8'h81: 7-segment output port ID.
REQ-005 SHALL have parameter INT_BASE, default 8'hF0: interrupt register block base (MASK=+0, PEND=+1, STAT=+2).
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port port_id, input, 8 bits: CPU I/O address.
REQ-009 SHALL have port out_port, input, 8 bits: CPU write data.
REQ-010 SHALL have port io_strobe, input, 1 bit: one-cycle CPU write qualifier.
REQ-011 SHALL have port in_port, output, 8 bits: read data to CPU.
REQ-012 SHALL have port sw_in, input, 8 bits: switch levels.
REQ-013 SHALL have port led_out, output, 8 bits: LED register.
REQ-014 SHALL have port seg_out, output, 8 bits: segment register.
REQ-015 SHALL have port ext_event, input, 4 bits: external interrupt sources.
REQ-016 SHALL have port interrupt, output, 1 bit: level interrupt request to CPU.

Function
REQ-017 SHALL, on clk edge with io_strobe=1, write out_port into led_out (port_id=LED_PORT), seg_out (SEG_PORT) or mask[3:0] (INT_BASE); all other IDs are ignored.
REQ-018 SHALL treat an io_strobe write to INT_BASE+1 as write-1-to-clear of pending[3:0]; out_port[7:4] is ignored.
REQ-019 SHALL register in_port each cycle from the current port_id (1-cycle latency): SW_PORT->sw_in, INT_BASE->{4'h0,mask}, INT_BASE+1->{4'h0,pending}, INT_BASE+2->{6'h0,state}, any other ID->8'h00.
REQ-020 SHALL set pending[n] one cycle after a rising edge is detected on the (optionally synchronized) ext_event[n]; a level held high sets it only once.
REQ-021 SHALL, when a set and a W1C clear hit the same pending bit in one cycle, leave the bit set (set wins).
REQ-022 SHALL implement FSM with states IDLE=2'd0, ASSERT=2'd1 and HOLDOFF=2'd2; encoding 2'd3 is illegal and SHALL return to IDLE.
REQ-023 SHALL go IDLE->ASSERT when (pending & mask)!=0.
REQ-024 SHALL go ASSERT->HOLDOFF on any io_strobe write to INT_BASE+1, with priority over the next rule.
REQ-025 SHALL go ASSERT->IDLE when (pending & mask)==0 through a mask write.
REQ-026 SHALL go HOLDOFF->IDLE unconditionally after exactly one cycle.
REQ-027 SHALL drive interrupt as a registered output that is 1 exactly while the state is ASSERT.
REQ-028 SHALL let a new edge during HOLDOFF set pending, so the interrupt reasserts after the FSM has passed through IDLE.

Reset
REQ-029 SHALL, while rst=1, asynchronously force led_out=0, seg_out=0, in_port=0, mask=0, pending=0, edge/sync history=0, state=IDLE and interrupt=0.
REQ-030 SHALL, when rst is asserted mid-ASSERT, drop interrupt immediately without waiting for a clk edge.
REQ-031 SHALL, after release, leave an ext_event already high at release unable to set pending until it falls and rises again.

Configuration
REQ-032 SHALL, with IO_RESP_SYNC_EN defined, pass ext_event through a 2-flop synchronizer before edge detection, so pending sets 3 cycles after the input rises.
REQ-033 SHALL, without IO_RESP_SYNC_EN, edge-detect ext_event directly against a 1-flop history, so pending sets 1 cycle after the input rises.

Verification
REQ-034 SHALL cover: strobe write port_id=8'h40, out_port=8'hA5 -> led_out=8'hA5 next cycle; a write to 8'h41 leaves led_out unchanged.
REQ-035 SHALL cover: sw_in=8'h3C, port_id=8'h20 -> in_port=8'h3C one cycle later; port_id=8'h55 -> in_port=8'h00.
REQ-036 SHALL cover: mask=4'h1, pulse ext_event[0] -> pending=4'h1 and interrupt=1 the following cycle; W1C 8'h01 to 8'hF1 -> interrupt=0 next cycle, state 2 for one cycle, then 0.
REQ-037 SHALL cover: mask=0, pulse ext_event[2] -> pending=4'h4 with interrupt=0; then write mask=4'h4 -> interrupt=1 within 2 cycles.
REQ-038 SHALL cover: an ext_event[1] edge in the same cycle as W1C 8'h02 -> pending[1] stays 1 and interrupt reasserts after HOLDOFF.
REQ-039 SHALL cover: assert rst during ASSERT -> interrupt=0, mask=0, pending=0 immediately; with ext_event high across the release, no interrupt afterwards.

Source files
------------

// File: rtl/io_port_responder.sv
// io_port_responder: CPU I/O port decoder with LED/segment registers, switch readback
// and an edge-triggered interrupt block. Define IO_RESP_SYNC_EN to add a 2-flop ext_event synchronizer.
module io_port_responder #(
    parameter logic [7:0] SW_PORT  = 8'h20,
    parameter logic [7:0] LED_PORT = 8'h40,
    parameter logic [7:0] SEG_PORT = 8'h81,
    parameter logic [7:0] INT_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strobe,
    output logic [7:0] in_port,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic [7:0] seg_out,
    input  logic [3:0] ext_event,
    output logic       interrupt
);

    localparam int unsigned EV_W      = 4;
    localparam logic [7:0]  MASK_PORT = INT_BASE;
    localparam logic [7:0]  PEND_PORT = INT_BASE + 8'd1;
    localparam logic [7:0]  STAT_PORT = INT_BASE + 8'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    logic [EV_W-1:0] mask;
    logic [EV_W-1:0] pending;
    logic [EV_W-1:0] ev_hist;
    logic [EV_W-1:0] ev_det;
    logic [1:0]      arm_cnt;

    logic            armed_c;
    logic            led_wr_c;
    logic            seg_wr_c;
    logic            mask_wr_c;
    logic            pend_wr_c;
    logic [EV_W-1:0] rise_c;
    logic [EV_W-1:0] clr_c;
    logic [EV_W-1:0] pending_nxt_c;
    logic [7:0]      rd_data_c;

`ifdef IO_RESP_SYNC_EN
    // Edges that flow out of the freshly reset pipeline are not real edges.
    localparam logic [1:0] ARM_LAST = 2'd3;

    logic [EV_W-1:0] ev_sync1;
    logic [EV_W-1:0] ev_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_sync1 <= '0;
            ev_sync2 <= '0;
        end else begin
            ev_sync1 <= ext_event;
            ev_sync2 <= ev_sync1;
        end
    end

    assign ev_det = ev_sync2;
`else
    localparam logic [1:0] ARM_LAST = 2'd1;

    assign ev_det = ext_event;
`endif

    // A level already high at reset release must not count as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt <= '0;
            ev_hist <= '0;
        end else begin
            if (arm_cnt != ARM_LAST) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            ev_hist <= ev_det;
        end
    end

    // Write decode, edge detect, pending update and read mux.
    always_comb begin
        armed_c       = (arm_cnt == ARM_LAST);
        led_wr_c      = io_strobe && (port_id == LED_PORT);
        seg_wr_c      = io_strobe && (port_id == SEG_PORT);
        mask_wr_c     = io_strobe && (port_id == MASK_PORT);
        pend_wr_c     = io_strobe && (port_id == PEND_PORT);
        rise_c        = ev_det & ~ev_hist & {EV_W{armed_c}};
        clr_c         = pend_wr_c ? out_port[EV_W-1:0] : '0;
        pending_nxt_c = (pending & ~clr_c) | rise_c;

        rd_data_c = 8'h00;
        if (port_id == SW_PORT) begin
            rd_data_c = sw_in;
        end else if (port_id == MASK_PORT) begin
            rd_data_c = {4'h0, mask};
        end else if (port_id == PEND_PORT) begin
            rd_data_c = {4'h0, pending};
        end else if (port_id == STAT_PORT) begin
            rd_data_c = {6'h0, state};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
            seg_out <= '0;
            mask    <= '0;
            pending <= '0;
            in_port <= '0;
        end else begin
            if (led_wr_c) begin
                led_out <= out_port;
            end
            if (seg_wr_c) begin
                seg_out <= out_port;
            end
            if (mask_wr_c) begin
                mask <= out_port[EV_W-1:0];
            end
            pending <= pending_nxt_c;
            in_port <= rd_data_c;
        end
    end

    // Interrupt FSM; interrupt is registered alongside the state it mirrors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((pending & mask) != '0) begin
                        state     <= ASSERT;
                        interrupt <= 1'b1;
                    end else begin
                        interrupt <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (pend_wr_c) begin
                        state     <= HOLDOFF;
                        interrupt <= 1'b0;
                    end else if (mask_wr_c && ((pending_nxt_c & out_port[EV_W-1:0]) == '0)) begin
                        state     <= IDLE;
                        interrupt <= 1'b0;
                    end else begin
                        interrupt <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule
